ap_ctrl_driver: RTL and testbench

- Synthesizable initiator for the HLS block-level ap_ctrl_chain handshake (ap_start/ap_ready/ap_done/ap_continue). It is the driving end of the same handshake our dataflow monitors observe.
- Issues a programmed number of kernel starts with a configurable inter-start gap. Applies configurable ap_continue back-pressure after each ap_done.
- Measures start-to-done latency per transaction (min/max/sum).
- Used in on-board self-test wrappers around hdv_engine and its pipelined loop sub-blocks.

---
 rtl/ap_ctrl_pkg.sv | 11 +
 rtl/ap_ctrl_driver_ts_fifo.sv | 40 ++++
 rtl/ap_ctrl_driver.sv | 106 ++++++++++
 tb/tb_ap_ctrl_driver.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ap_ctrl_pkg.sv
// ap_ctrl_pkg: shared FSM state, latency statistics type and constants for the ap_ctrl_chain driver
package ap_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, ARM, START, GAP, DRAIN} state_t;
  localparam int STAT_W = 32;
  localparam logic [STAT_W-1:0] LAT_INIT_MIN = '1;
  typedef struct packed {
    logic [STAT_W-1:0] min;
    logic [STAT_W-1:0] max;
    logic [STAT_W-1:0] sum;
  } stat_t;
endpackage

// File: rtl/ap_ctrl_driver_ts_fifo.sv
// ts_fifo: first-word-fall-through timestamp FIFO tracking outstanding kernel starts
module ts_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rp];
  // storage is written only on an accepted push and needs no reset
  always_ff @(posedge clock) if (do_push) mem[wp] <= din;
  // pointers and occupancy; a same-cycle push and pop leaves count unchanged
  always_ff @(posedge clock) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/ap_ctrl_driver.sv
// ap_ctrl_driver: ap_ctrl_chain initiator with start pacing, continue back-pressure and latency stats
module ap_ctrl_driver
  import ap_ctrl_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int TXN_W = 16,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_go,
  input  logic [TXN_W-1:0] cfg_num_txn,
  input  logic [TXN_W-1:0] cfg_gap,
  input  logic [TXN_W-1:0] cfg_cont_delay,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_continue,
  output logic             busy,
  output logic             run_done,
  output logic [TXN_W-1:0] txn_started,
  output logic [TXN_W-1:0] txn_done,
  output logic [CNT_W-1:0] lat_min,
  output logic [CNT_W-1:0] lat_max,
  output logic [CNT_W-1:0] lat_sum,
  output logic             err_proto
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t state, nxt;
  logic [CNT_W-1:0] cyc, ts, ts_head, lat;
  logic [TXN_W-1:0] num_r, gap_r, cdel_r, gcnt, hold, dly;
  logic [CW-1:0] count;
  logic full, empty, push, hs, pop, go, gap_end, drain_end;
  assign go = state == IDLE && cmd_go;
  assign ap_start = state == START;
  assign busy = state != IDLE;
  assign push = ap_start && ap_ready;
  assign dly = busy ? cdel_r : '0;
  assign ap_continue = ap_done && hold == dly;
  assign hs = ap_done && ap_continue;
  assign pop = hs && !empty;
  assign lat = cyc - ts_head;
  assign gap_end = gcnt == gap_r - 1'b1;
  assign drain_end = txn_done == num_r && count == '0;
  ts_fifo #(.DEPTH(DEPTH), .W(CNT_W)) u_fifo (
    .clock, .reset, .push, .pop, .din(ts), .dout(ts_head), .count, .full, .empty
  );
  // start sequencing; the last GAP cycle arms directly so cfg_gap idle cycles separate starts
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (cmd_go) nxt = cfg_num_txn == '0 ? DRAIN : ARM;
      ARM:     if (!full) nxt = START;
      START:   if (ap_ready) nxt = txn_started + 1'b1 == num_r ? DRAIN : gap_r == '0 ? ARM : GAP;
      GAP:     if (gap_end) nxt = full ? ARM : START;
      DRAIN:   if (drain_end) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // state, timestamps, handshake counters and latency statistics
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      cyc <= '0;
      ts <= '0;
      gcnt <= '0;
      hold <= '0;
      num_r <= '0;
      gap_r <= '0;
      cdel_r <= '0;
      txn_started <= '0;
      txn_done <= '0;
      run_done <= 1'b0;
      err_proto <= 1'b0;
      lat_min <= CNT_W'(LAT_INIT_MIN);
      lat_max <= '0;
      lat_sum <= '0;
    end else begin
      state <= nxt;
      cyc <= cyc + 1'b1;
      gcnt <= state == GAP ? gcnt + 1'b1 : '0;
      hold <= hs || !ap_done ? '0 : hold + 1'b1;
      run_done <= state == DRAIN && drain_end;
      if (nxt == START && state != START) ts <= cyc + 1'b1;
      if (push) txn_started <= txn_started + 1'b1;
      if (pop) begin
        txn_done <= txn_done + 1'b1;
        lat_min <= lat < lat_min ? lat : lat_min;
        lat_max <= lat > lat_max ? lat : lat_max;
        lat_sum <= lat_sum + lat;
      end
      if (hs && empty) err_proto <= 1'b1;
      if (go) begin
        num_r <= cfg_num_txn;
        gap_r <= cfg_gap;
        cdel_r <= cfg_cont_delay;
        txn_started <= '0;
        txn_done <= '0;
        err_proto <= 1'b0;
        lat_min <= CNT_W'(LAT_INIT_MIN);
        lat_max <= '0;
        lat_sum <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ap_ctrl_driver.sv
// tb_ap_ctrl_driver: directed self-checking bench with a kernel model and latency scoreboard
module tb_ap_ctrl_driver;
  import ap_ctrl_pkg::*;
  typedef struct {
    stat_t s;
    int    n;
    bit    l;
  } exp_t;
  logic clock = 0, reset = 0, cmd_go = 0;
  logic [15:0] cfg_num_txn = 0, cfg_gap = 0, cfg_cont_delay = 0;
  logic ap_start, ap_ready, ap_done, ap_continue, busy, run_done, err_proto;
  logic [15:0] txn_started, txn_done;
  logic [31:0] lat_min, lat_max, lat_sum;
  logic ready_en = 1, kdone_en = 1, kdone = 0, spur = 0;
  int tests = 0, fails = 0, kc = 0, rd_cnt = 0, cd_exp = 0, exp_sep = 0, last_rise = -1;
  int kq[$];
  int sq[$];
  exp_t rq[$];
  always #5 clock = ~clock;
  assign ap_ready = ap_start && ready_en;
  assign ap_done = kdone | spur;
  ap_ctrl_driver dut (
    .clock(clock), .reset(reset), .cmd_go(cmd_go), .cfg_num_txn(cfg_num_txn),
    .cfg_gap(cfg_gap), .cfg_cont_delay(cfg_cont_delay), .ap_start(ap_start),
    .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue), .busy(busy),
    .run_done(run_done), .txn_started(txn_started), .txn_done(txn_done),
    .lat_min(lat_min), .lat_max(lat_max), .lat_sum(lat_sum), .err_proto(err_proto)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // kernel: ready follows ap_start; done is raised 10 cycles after each accept and held until continue
  initial forever begin
    @(negedge clock);
    if (!reset) kq.delete();
    else begin
      if (ap_done && ap_continue && kdone) void'(kq.pop_front());
      if (ap_start && ap_ready) kq.push_back(kc + 10);
    end
    @(posedge clock);
    #2;
    kc++;
    kdone = kdone_en && kq.size() > 0 && kq[0] <= kc;
  end
  // monitor: timestamp scoreboard, per-handshake stats, continue delay, start spacing, run results
  initial begin
    stat_t m;
    int m_done, pstart, l;
    bit pend, pdone, phs, pst;
    exp_t e;
    m = '{LAT_INIT_MIN, 0, 0};
    m_done = 0; pstart = 0; pend = 0; pdone = 0; phs = 0; pst = 0;
    forever begin
      @(negedge clock);
      if (pend) begin
        chk("hs_lat_min", lat_min, m.min);
        chk("hs_lat_max", lat_max, m.max);
        chk("hs_lat_sum", lat_sum, m.sum);
        chk("hs_txn_done", txn_done, m_done);
        pend = 0;
      end
      if (!reset) begin
        sq.delete();
        m = '{LAT_INIT_MIN, 0, 0};
        m_done = 0;
      end else begin
        if (cmd_go && !busy) begin
          m = '{LAT_INIT_MIN, 0, 0};
          m_done = 0;
          sq.delete();
        end
        if (ap_done && (!pdone || phs)) pstart = kc;
        if (ap_done && ap_continue) begin
          chk("cont_delay", kc - pstart, cd_exp);
          if (sq.size() > 0) begin
            l = kc - sq.pop_front();
            m.min = l < m.min ? l : m.min;
            m.max = l > m.max ? l : m.max;
            m.sum = m.sum + l;
            m_done++;
          end
          pend = 1;
        end
        if (ap_start && ap_ready) sq.push_back(kc);
        if (ap_start && !pst) begin
          if (exp_sep != 0 && last_rise >= 0) chk("start_sep", kc - last_rise, exp_sep);
          last_rise = kc;
        end
        if (run_done) begin
          rd_cnt++;
          if (rq.size() > 0) begin
            e = rq.pop_front();
            chk("run_started", txn_started, e.n);
            chk("run_done_cnt", txn_done, e.n);
            chk("run_busy", busy, 0);
            if (e.l) begin
              chk("run_lat_min", lat_min, e.s.min);
              chk("run_lat_max", lat_max, e.s.max);
              chk("run_lat_sum", lat_sum, e.s.sum);
            end
          end
        end
      end
      pdone = ap_done;
      phs = ap_done && ap_continue;
      pst = ap_start;
    end
  end
  task automatic run(input int n, input int g, input int cd, input int sep, input bit lchk, input int lat);
    exp_t e;
    e.s.min = n != 0 ? lat : LAT_INIT_MIN;
    e.s.max = n != 0 ? lat : 0;
    e.s.sum = lat * n;
    e.n = n;
    e.l = lchk;
    rq.push_back(e);
    @(posedge clock);
    #1;
    exp_sep = sep;
    cd_exp = cd;
    last_rise = -1;
    cmd_go = 1;
    cfg_num_txn = 16'(n);
    cfg_gap = 16'(g);
    cfg_cont_delay = 16'(cd);
    @(posedge clock);
    #1;
    cmd_go = 0;
  endtask
  task automatic finish_run(input int target);
    for (int i = 0; i < 2000 && rd_cnt < target; i++) @(negedge clock);
    repeat (3) @(negedge clock);
    chk("run_done_pulses", rd_cnt, target);
    chk("busy_after_run", busy, 0);
    @(posedge clock);
    #1;
    cd_exp = 0;
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: run did not complete, %0d tests run", tests);
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ap_start", ap_start, 0);
    chk("rst_ap_continue", ap_continue, 0);
    chk("rst_busy", busy, 0);
    chk("rst_run_done", run_done, 0);
    chk("rst_txn_started", txn_started, 0);
    chk("rst_txn_done", txn_done, 0);
    chk("rst_lat_min", lat_min, LAT_INIT_MIN);
    chk("rst_lat_max", lat_max, 0);
    chk("rst_lat_sum", lat_sum, 0);
    chk("rst_err_proto", err_proto, 0);
    @(posedge clock);
    #1;
    reset = 1;
    run(3, 0, 0, 2, 1, 10);
    @(negedge clock);
    chk("busy_in_run", busy, 1);
    finish_run(1);
    run(3, 5, 0, 6, 1, 10);
    finish_run(2);
    run(3, 5, 3, 6, 1, 13);
    finish_run(3);
    kdone_en = 0;
    run(6, 0, 0, 0, 0, 0);
    for (int i = 0; i < 200 && txn_started != 4; i++) @(negedge clock);
    repeat (6) @(negedge clock);
    chk("depth_stall_start", ap_start, 0);
    chk("depth_stall_count", txn_started, 4);
    @(posedge clock);
    #1;
    kdone_en = 1;
    finish_run(4);
    kdone_en = 0;
    run(6, 0, 0, 0, 0, 0);
    for (int i = 0; i < 200 && txn_started != 2; i++) @(negedge clock);
    @(posedge clock);
    #1;
    ready_en = 0;
    reset = 0;
    @(negedge clock);
    chk("abort_start_before", ap_start, 1);
    @(negedge clock);
    chk("abort_ap_start", ap_start, 0);
    chk("abort_busy", busy, 0);
    chk("abort_txn_started", txn_started, 0);
    chk("abort_run_done", run_done, 0);
    @(posedge clock);
    #1;
    reset = 1;
    ready_en = 1;
    kdone_en = 1;
    rq.delete();
    repeat (10) @(negedge clock);
    chk("abort_no_run_done", rd_cnt, 4);
    @(posedge clock);
    #1;
    spur = 1;
    @(negedge clock);
    chk("spur_continue", ap_continue, 1);
    @(posedge clock);
    #1;
    spur = 0;
    @(negedge clock);
    chk("spur_err_proto", err_proto, 1);
    chk("spur_txn_done", txn_done, 0);
    chk("spur_txn_started", txn_started, 0);
    repeat (5) @(negedge clock);
    chk("spur_err_sticky", err_proto, 1);
    run(0, 0, 0, 0, 1, 0);
    @(negedge clock);
    chk("go_clears_err", err_proto, 0);
    finish_run(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
